// File: rtl/morse_pkg.sv
// Shared types and default timing constants for the morse symbol classifier.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    LGAP  = 2'd3
  } state_t;

  localparam int unsigned DEF_DASH_UNITS       = 2;
  localparam int unsigned DEF_LETTER_GAP_UNITS = 2;
  localparam int unsigned DEF_WORD_GAP_UNITS   = 5;
  localparam int unsigned DEF_CNT_W            = 4;

  // Cycles after reset before the edge detector trusts the synchronized level.
  localparam int unsigned SYNC_SETTLE = 3;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the raw key plus registered rise/fall detection.
module key_sync
  import morse_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic rise,
  output logic fall
);

  logic                   sync1;
  logic                   sync2;
  logic                   prev;
  logic [SYNC_SETTLE-1:0] settle;
  logic                   settled;

  // Edges are suppressed until the synchronizer and the edge register have
  // been refilled after reset, so a key held down across reset is not seen
  // as a press.
  assign settled = settle[SYNC_SETTLE-1];

  // Synchronize, keep a delayed copy, and emit one-cycle edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      prev   <= 1'b0;
      settle <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync1  <= key;
      sync2  <= sync1;
      prev   <= sync2;
      settle <= {settle[SYNC_SETTLE-2:0], 1'b1};
      rise   <= settled &  sync2 & ~prev;
      fall   <= settled & ~sync2 &  prev;
    end
  end

endmodule

// File: rtl/morse_symbol_classifier.sv
// Classifies key-down marks as dots/dashes and key-up gaps as letter/word ends.
module morse_symbol_classifier
  import morse_pkg::*;
#(
  parameter int unsigned DASH_UNITS       = DEF_DASH_UNITS,
  parameter int unsigned LETTER_GAP_UNITS = DEF_LETTER_GAP_UNITS,
  parameter int unsigned WORD_GAP_UNITS   = DEF_WORD_GAP_UNITS,
  parameter int unsigned CNT_W            = DEF_CNT_W
) (
  input  logic clk_100Mhz,
  input  logic reset,
  input  logic key_in,
  input  logic tick,
  output logic timer_restart,
  output logic sym_valid,
  output logic sym_is_dash,
  output logic letter_end,
  output logic word_end
);

  localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_UNITS);
  localparam logic [CNT_W-1:0] LETTER_C = CNT_W'(LETTER_GAP_UNITS);
  localparam logic [CNT_W-1:0] WORD_C   = CNT_W'(WORD_GAP_UNITS);

  logic             rise;
  logic             fall;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_inc;
  logic             restart_n;
  logic             valid_n;
  logic             dash_n;
  logic             letter_n;
  logic             word_n;

  key_sync u_key_sync (
    .clk  (clk_100Mhz),
    .rst  (reset),
    .key  (key_in),
    .rise (rise),
    .fall (fall)
  );

  // Saturating unit count; a very long mark must never wrap back to a dot.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  // Next-state and next-output logic; an edge always takes priority over a
  // tick in the same cycle, which discards that tick.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    restart_n = 1'b0;
    valid_n   = 1'b0;
    dash_n    = sym_is_dash;
    letter_n  = 1'b0;
    word_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n   = MARK;
          cnt_n     = '0;
          restart_n = 1'b1;
        end
      end
      MARK: begin
        if (fall) begin
          valid_n   = 1'b1;
          dash_n    = (cnt >= DASH_C);
          cnt_n     = '0;
          restart_n = 1'b1;
          state_n   = SPACE;
        end else if (tick) begin
          cnt_n = cnt_inc;
        end
      end
      SPACE: begin
        if (rise) begin
          state_n   = MARK;
          cnt_n     = '0;
          restart_n = 1'b1;
        end else if (tick) begin
          cnt_n = cnt_inc;
          if (cnt_inc == LETTER_C) begin
            letter_n = 1'b1;
            state_n  = LGAP;
          end
        end
      end
      LGAP: begin
        if (rise) begin
          state_n   = MARK;
          cnt_n     = '0;
          restart_n = 1'b1;
        end else if (tick) begin
          cnt_n = cnt_inc;
          if (cnt_inc == WORD_C) begin
            word_n  = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_100Mhz or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      timer_restart <= 1'b0;
      sym_valid     <= 1'b0;
      sym_is_dash   <= 1'b0;
      letter_end    <= 1'b0;
      word_end      <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      timer_restart <= restart_n;
      sym_valid     <= valid_n;
      sym_is_dash   <= dash_n;
      letter_end    <= letter_n;
      word_end      <= word_n;
    end
  end

endmodule
